lc3_memio: RTL
==============

// Module: lc3_memio
// PURPOSE
//  Memory-bus slave directly downstream of the lc3 core: consumes memory_addr/memory_din/memWE,
//  returns memory_dout. Routes ordinary addresses to external RAM and decodes the LC-3 device page
//  (xFE00-xFFFF) into keyboard (KBSR/KBDR), display (DSR/DDR) and machine control (MCR) registers
//  with valid/ready byte-stream handshakes to the keyboard source and display sink.
// PARAMETERS
//  KBSR_ADDR  16'hFE00  keyboard status; bit15 ready (RO), bit14 IE (RW)
//  KBDR_ADDR  16'hFE02  keyboard data (RO); read clears KBSR[15]
//  DSR_ADDR   16'hFE04  display status; bit15 ready (RO)
//  DDR_ADDR   16'hFE06  display data (WO, reads 0)
//  MCR_ADDR   16'hFFFE  machine control; bit15 run (RW)
//  DEV_BASE   16'hFE00  first address of device page (page runs to xFFFF)
// PORTS
//  clk          in   1   system clock, all state updates on rising edge
//  rst          in   1   synchronous, active-high reset
//  memory_addr  in   16  CPU address
//  memory_din   in   16  CPU write data
//  memWE        in   1   CPU write enable
//  memory_dout  out  16  read data to CPU (combinational)
//  ram_addr     out  16  RAM address (= memory_addr)
//  ram_din      out  16  RAM write data (= memory_din)
//  ram_we       out  1   RAM write enable
//  ram_dout     in   16  RAM read data (async read)
//  kb_valid     in   1   keyboard byte available
//  kb_data      in   8   keyboard byte
//  kb_ready     out  1   block can accept keyboard byte
//  kb_irq       out  1   keyboard interrupt request
//  disp_valid   out  1   display byte pending
//  disp_data    out  8   display byte
//  disp_ready   in   1   display sink accepts byte
//  run          out  1   MCR[15], core clock-enable request
// BEHAVIOUR
//  Reset: KBSR=0, KBDR=0, disp busy=0, disp_valid=0, disp_data=0, MCR=x8000 (run=1).
//   Hence kb_ready=1, kb_irq=0, DSR reads x8000 after reset.
//  Decode: dev = (memory_addr >= DEV_BASE). ram_we = memWE & ~dev; device writes never reach RAM.
//  Read mux (combinational, zero latency): ~dev -> ram_dout; KBSR -> {rdy,ie,14'b0};
//   KBDR -> {8'h00,kbdata}; DSR -> {~busy,15'b0}; MCR -> MCR; any other dev address -> x0000.
//  Keyboard: kb_ready = ~KBSR[15]. Edge with kb_valid&kb_ready: KBDR<=kb_data, KBSR[15]<=1.
//   Read side effect: edge with memory_addr==KBDR_ADDR & ~memWE clears KBSR[15]; holding the
//   address further cycles re-reads same KBDR. Accept and clear cannot coincide (ready=0 then).
//   Write to KBSR: only IE<=memory_din[14]; bit15 unchanged. Write to KBDR ignored.
//   kb_irq = KBSR[15] & KBSR[14] (combinational from registers).
//  Display FSM, 2 states: IDLE (DSR[15]=1, disp_valid=0) / BUSY (DSR[15]=0, disp_valid=1).
//   IDLE -> BUSY on edge with memWE & addr==DDR_ADDR: disp_data<=memory_din[7:0].
//   BUSY -> IDLE on edge with disp_valid&disp_ready. disp_data stable while BUSY.
//   DDR write while BUSY (incl. memWE held >1 cycle after accepting write) is dropped: no
//   duplicate characters. Write to DSR ignored.
//  MCR: write sets MCR<=memory_din (only bit15 meaningful; low bits stored). run=MCR[15].
//  rst mid-transfer: pending display byte discarded, disp_valid drops next edge; captured
//   keyboard byte discarded.
//  Any decoded-but-unmapped device write: no state change, ram_we=0.
// TESTING
//  T1 reset: rst=1 one edge -> kb_ready=1, disp_valid=0, run=1, read xFE04 -> x8000, xFE00 -> 0.
//  T2 RAM: write x1234 @x3000 -> ram_we=1 one cycle; ram_dout=x1234 -> memory_dout=x1234;
//   write @xFE10 -> ram_we=0, read xFE10 -> 0.
//  T3 keyboard: kb_valid, kb_data=x41 -> next cycle kb_ready=0, xFE00 reads x8000, xFE02 reads
//   x0041; after read edge KBSR reads 0, kb_ready=1; second byte x42 held until then.
//  T4 irq: write x4000 to xFE00, inject x55 -> kb_irq=1; read xFE02 -> kb_irq=0.
//  T5 display: disp_ready=0, write x0163 to xFE06 for 3 cycles -> disp_valid=1, disp_data=x63,
//   DSR=0; then write x64 ignored; disp_ready=1 one cycle -> exactly one byte x63, DSR=x8000.
//  T6 MCR/reset mid-op: write x0000 to xFFFE -> run=0; with display BUSY assert rst -> disp_valid=0, run=1.

Source files
------------

// File: rtl/lc3_memio.sv
// LC-3 memory-bus slave: passes ordinary addresses through to external RAM and
// decodes the xFE00-xFFFF device page into keyboard, display and machine-control registers.
module lc3_memio #(
  parameter logic [15:0] KBSR_ADDR = 16'hFE00,
  parameter logic [15:0] KBDR_ADDR = 16'hFE02,
  parameter logic [15:0] DSR_ADDR  = 16'hFE04,
  parameter logic [15:0] DDR_ADDR  = 16'hFE06,
  parameter logic [15:0] MCR_ADDR  = 16'hFFFE,
  parameter logic [15:0] DEV_BASE  = 16'hFE00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] memory_addr,
  input  logic [15:0] memory_din,
  input  logic        memWE,
  output logic [15:0] memory_dout,
  output logic [15:0] ram_addr,
  output logic [15:0] ram_din,
  output logic        ram_we,
  input  logic [15:0] ram_dout,
  input  logic        kb_valid,
  input  logic [7:0]  kb_data,
  output logic        kb_ready,
  output logic        kb_irq,
  output logic        disp_valid,
  output logic [7:0]  disp_data,
  input  logic        disp_ready,
  output logic        run
);
  typedef enum logic {DISP_IDLE, DISP_BUSY} disp_st_e;

  disp_st_e    disp_st_q, disp_st_d;
  logic        kb_rdy_q, kb_rdy_d;
  logic        kb_ie_q, kb_ie_d;
  logic [7:0]  kbdr_q, kbdr_d;
  logic [7:0]  disp_data_q, disp_data_d;
  logic [15:0] mcr_q, mcr_d;
  logic        dev;

  assign dev        = (memory_addr >= DEV_BASE);
  assign ram_addr   = memory_addr;
  assign ram_din    = memory_din;
  assign ram_we     = memWE & ~dev;
  assign kb_ready   = ~kb_rdy_q;
  assign kb_irq     = kb_rdy_q & kb_ie_q;
  assign disp_valid = (disp_st_q == DISP_BUSY);
  assign disp_data  = disp_data_q;
  assign run        = mcr_q[15];

  always_comb begin
    memory_dout = 16'h0000;
    if (!dev) begin
      memory_dout = ram_dout;
    end else begin
      case (memory_addr)
        KBSR_ADDR: memory_dout = {kb_rdy_q, kb_ie_q, 14'b0};
        KBDR_ADDR: memory_dout = {8'h00, kbdr_q};
        DSR_ADDR:  memory_dout = {disp_st_q == DISP_IDLE, 15'b0};
        MCR_ADDR:  memory_dout = mcr_q;
        default:   memory_dout = 16'h0000;
      endcase
    end
  end

  always_comb begin
    kb_rdy_d    = kb_rdy_q;
    kb_ie_d     = kb_ie_q;
    kbdr_d      = kbdr_q;
    disp_st_d   = disp_st_q;
    disp_data_d = disp_data_q;
    mcr_d       = mcr_q;

    // Capture only happens while empty, so it can never race the read-clear.
    if (kb_valid && !kb_rdy_q) begin
      kbdr_d   = kb_data;
      kb_rdy_d = 1'b1;
    end else if (memory_addr == KBDR_ADDR && !memWE) begin
      kb_rdy_d = 1'b0;
    end
    if (memWE && memory_addr == KBSR_ADDR) kb_ie_d = memory_din[14];

    // DDR writes seen while busy are dropped so a held memWE cannot duplicate a char.
    case (disp_st_q)
      DISP_IDLE: if (memWE && memory_addr == DDR_ADDR) begin
        disp_st_d   = DISP_BUSY;
        disp_data_d = memory_din[7:0];
      end
      DISP_BUSY: if (disp_ready) disp_st_d = DISP_IDLE;
      default:   disp_st_d = DISP_IDLE;
    endcase

    if (memWE && memory_addr == MCR_ADDR) mcr_d = memory_din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      kb_rdy_q    <= 1'b0;
      kb_ie_q     <= 1'b0;
      kbdr_q      <= 8'h00;
      disp_st_q   <= DISP_IDLE;
      disp_data_q <= 8'h00;
      mcr_q       <= 16'h8000;
    end else begin
      kb_rdy_q    <= kb_rdy_d;
      kb_ie_q     <= kb_ie_d;
      kbdr_q      <= kbdr_d;
      disp_st_q   <= disp_st_d;
      disp_data_q <= disp_data_d;
      mcr_q       <= mcr_d;
    end
  end
endmodule
